ps2_digit_entry: RTL
====================

// Module: ps2_digit_entry
// PURPOSE
// Parametrised successor to the combinational PS/2 digit detector. Accepts a
// stream of PS/2 set-2 scancode bytes, filters make/break/extended prefixes,
// decodes digit keys 0-9, and keeps a NUM_DIGITS-deep entry buffer with
// backspace and clear. Drives a time-multiplexed 7-segment display.
// Sits between the PS/2 receiver and the board display in the typing tutor.
// PARAMETERS
// NUM_DIGITS      4      buffer depth = displayed digit count (1..8)
// REFRESH_CYCLES  100000 clk cycles each digit is lit per scan step (>=2)
// PORTS
// clk         in   1             system clock, rising edge
// rst_n       in   1             asynchronous active-low reset
// code_valid  in   1             1-cycle strobe: code holds a new scancode byte
// code        in   8             scancode byte from PS/2 receiver
// change      out  1             1-cycle pulse: a digit was appended
// digit_out   out  4             value of last appended digit (held)
// count       out  $clog2(NUM_DIGITS+1)  digits currently in buffer
// seg         out  7             segments a..g = seg[0..6], active low
// an          out  NUM_DIGITS    digit anodes, active low, an[0] = rightmost
// BEHAVIOUR
// Reset (async, rst_n=0): FSM=IDLE, buffer all 0, count=0, change=0,
//   digit_out=0, scan_idx=0, refresh counter=0, seg=7'h7F, an=all 1s.
//   Reset mid-sequence discards any pending F0/E0 prefix.
// Prefix FSM advances only on code_valid:
//   IDLE:      F0->BREAK; E0->EXT; else process code as make code, stay IDLE.
//   BREAK:     any code consumed (no action) -> IDLE.
//   EXT:       F0->EXT_BREAK; else consumed (extended keys ignored) -> IDLE.
//   EXT_BREAK: any code consumed -> IDLE.
// Make-code actions (IDLE only):
//   digits 45,16,1E,26,25,2E,36,3D,3E,46 (hex) = 0..9: shift buffer left one
//     position, new digit enters position 0; count = min(count+1,NUM_DIGITS);
//     when full the oldest digit (position NUM_DIGITS-1) is dropped.
//   66 (backspace): shift right, position NUM_DIGITS-1 <= 0, count-1;
//     no-op when count=0.
//   76 (escape): buffer cleared, count=0.
//   other codes: ignored.
// Latency: buffer, count, digit_out, change update on the clk edge after the
//   code_valid cycle; change high exactly 1 cycle per appended digit, never
//   for break/extended/backspace/escape. Back-to-back code_valid every cycle
//   must be handled with no loss.
// Display scan: refresh counter counts 0..REFRESH_CYCLES-1, then wraps to 0
//   and scan_idx advances, wrapping NUM_DIGITS-1 -> 0.
//   Registered outputs, valid 1 cycle after scan_idx/buffer change:
//   scan_idx < count: an = ~(1<<scan_idx), seg = 7-seg pattern of that digit
//     (0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02,
//     7=7'h78, 8=7'h00, 9=7'h10).
//   scan_idx >= count (unused position): an = all 1s, seg = 7'h7F (blank).
//   Scan runs independently of code input; entry never stalls scan.
// TESTING
// 1. Reset, then codes 16,F0,16 -> one change pulse, digit_out=1, count=1;
//    break code produces no second pulse.
// 2. Enter 1,2,3,4,5 with NUM_DIGITS=4 -> count saturates at 4, buffer
//    {2,3,4,5} (pos3..0), 5 change pulses.
// 3. Buffer {_,_,7,9}: send 66 -> count=1, pos0=7; send 66 twice more ->
//    count=0, no underflow, no change pulse.
// 4. E0,45 then E0,F0,45 -> buffer unchanged, no change pulse;
//    next 45 -> digit 0 appended.
// 5. REFRESH_CYCLES=4, count=2: an cycles 1110,1101,1111,1111 every 4 clks;
//    seg 7'h7F whenever an all 1s.
// 6. Send F0, assert rst_n=0 for 1 clk, then 26 -> digit 3 appended
//    (prefix discarded by reset); escape 76 -> count=0, an all 1s.

Source files
------------

// File: rtl/ps2_digit_entry.sv
// PS/2 set-2 digit entry buffer with backspace/clear and a muxed 7-seg scan.
// Ports: clk, rst_n, code_valid/code in; change, digit_out, count, seg, an out.
module ps2_digit_entry #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            code_valid,
  input  logic [7:0]                      code,
  output logic                            change,
  output logic [3:0]                      digit_out,
  output logic [$clog2(NUM_DIGITS+1)-1:0] count,
  output logic [6:0]                      seg,
  output logic [NUM_DIGITS-1:0]           an
);

  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int RW = $clog2(REFRESH_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BREAK,
    S_EXT,
    S_EXT_BREAK
  } state_t;

  state_t          r_state;
  logic [3:0]      r_buf [NUM_DIGITS];
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_dout;
  logic            r_change;
  logic [RW-1:0]   r_ref;
  logic [SW-1:0]   r_scan;
  logic [6:0]      r_seg;
  logic [NUM_DIGITS-1:0] r_an;

  logic            w_is_dig;
  logic [3:0]      w_dig;
  logic            w_lit;
  logic [3:0]      w_cur;
  logic [6:0]      w_pat;

  always_comb begin
    w_is_dig = 1'b1;
    w_dig    = 4'd0;
    case (code)
      8'h45:   w_dig = 4'd0;
      8'h16:   w_dig = 4'd1;
      8'h1E:   w_dig = 4'd2;
      8'h26:   w_dig = 4'd3;
      8'h25:   w_dig = 4'd4;
      8'h2E:   w_dig = 4'd5;
      8'h36:   w_dig = 4'd6;
      8'h3D:   w_dig = 4'd7;
      8'h3E:   w_dig = 4'd8;
      8'h46:   w_dig = 4'd9;
      default: w_is_dig = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_dout   <= 4'd0;
      r_change <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++)
        r_buf[i] <= 4'd0;
    end else begin
      r_change <= 1'b0;
      if (code_valid) begin
        case (r_state)
          S_IDLE: begin
            if (code == 8'hF0) begin
              r_state <= S_BREAK;
            end else if (code == 8'hE0) begin
              r_state <= S_EXT;
            end else if (w_is_dig) begin
              // oldest digit falls off the top when full
              for (int i = NUM_DIGITS - 1; i > 0; i--)
                r_buf[i] <= r_buf[i-1];
              r_buf[0] <= w_dig;
              r_dout   <= w_dig;
              r_change <= 1'b1;
              if (r_cnt != CW'(NUM_DIGITS))
                r_cnt <= r_cnt + 1'b1;
            end else if (code == 8'h66) begin
              if (r_cnt != '0) begin
                for (int i = 0; i < NUM_DIGITS - 1; i++)
                  r_buf[i] <= r_buf[i+1];
                r_buf[NUM_DIGITS-1] <= 4'd0;
                r_cnt <= r_cnt - 1'b1;
              end
            end else if (code == 8'h76) begin
              for (int i = 0; i < NUM_DIGITS; i++)
                r_buf[i] <= 4'd0;
              r_cnt <= '0;
            end
          end
          S_BREAK:     r_state <= S_IDLE;
          S_EXT: begin
            if (code == 8'hF0)
              r_state <= S_EXT_BREAK;
            else
              r_state <= S_IDLE;
          end
          S_EXT_BREAK: r_state <= S_IDLE;
          default:     r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign w_lit = (32'(r_scan) < 32'(r_cnt));
  assign w_cur = r_buf[r_scan];

  always_comb begin
    w_pat = 7'h7F;
    case (w_cur)
      4'd0:    w_pat = 7'h40;
      4'd1:    w_pat = 7'h79;
      4'd2:    w_pat = 7'h24;
      4'd3:    w_pat = 7'h30;
      4'd4:    w_pat = 7'h19;
      4'd5:    w_pat = 7'h12;
      4'd6:    w_pat = 7'h02;
      4'd7:    w_pat = 7'h78;
      4'd8:    w_pat = 7'h00;
      4'd9:    w_pat = 7'h10;
      default: w_pat = 7'h7F;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref  <= '0;
      r_scan <= '0;
      r_seg  <= 7'h7F;
      r_an   <= '1;
    end else begin
      if (r_ref == RW'(REFRESH_CYCLES - 1)) begin
        r_ref <= '0;
        if (r_scan == SW'(NUM_DIGITS - 1))
          r_scan <= '0;
        else
          r_scan <= r_scan + 1'b1;
      end else begin
        r_ref <= r_ref + 1'b1;
      end
      // positions beyond the entered count stay dark
      if (w_lit) begin
        r_an  <= ~(NUM_DIGITS'(1) << r_scan);
        r_seg <= w_pat;
      end else begin
        r_an  <= '1;
        r_seg <= 7'h7F;
      end
    end
  end

  assign change    = r_change;
  assign digit_out = r_dout;
  assign count     = r_cnt;
  assign seg       = r_seg;
  assign an        = r_an;

endmodule
